hack_rom_loader: RTL and testbench

Parametrised loader that streams a program image from the HPS download channel (`ioctl_*`) into the Hack instruction ROM while holding the CPU in reset. It sits between `hps_io` and the writable instruction ROM in the `emu` top level. It generalises ROM loading in address width, byte order and tail handling. It adds a reset-hold sequencer, tail zero-fill, overflow detection and a load checksum.

---
 rtl/hack_rom_loader.sv | 164 ++++++++++++++++
 tb/tb_hack_rom_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_rom_loader.sv
// Streams a program image from the HPS download channel into the Hack instruction ROM,
// holding the CPU in reset during the load and for a fixed time afterwards. Optionally
// zero-fills the ROM above the highest written word, and reports overflow, word count
// and a 16-bit checksum of the loaded image.
module hack_rom_loader #(
   parameter int unsigned ADDR_W      = 15,
   parameter bit          BYTE_SWAP   = 1'b0,
   parameter bit          CLEAR_TAIL  = 1'b1,
   parameter int unsigned HOLD_CYCLES = 16
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [15:0]       ioctl_dout,
   output logic              ioctl_wait,
   output logic              rom_we,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [15:0]       rom_din,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              overflow,
   output logic [ADDR_W:0]   load_words,
   output logic [15:0]       checksum
);

   localparam int unsigned   CntW     = $clog2(HOLD_CYCLES + 1);
   localparam logic [CntW-1:0] HoldInit = CntW'(HOLD_CYCLES);
   localparam logic [ADDR_W:0] Depth  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] OneW   = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {StHold, StRun, StLoad, StClear} state_e;

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               dl_prev_q;
   logic [ADDR_W:0]    hw_q, hw_d;          // one past the highest written word
   logic [ADDR_W-1:0]  clr_ptr_q, clr_ptr_d;
   logic               rom_we_d;
   logic [ADDR_W-1:0]  rom_addr_d;
   logic [15:0]        rom_din_d;
   logic               load_done_d, overflow_d;
   logic [ADDR_W:0]    load_words_d;
   logic [15:0]        checksum_d;

   logic               dl_rise, dl_fall, word_ok;
   logic [ADDR_W-1:0]  word_idx;
   logic [ADDR_W:0]    wr_top;
   logic [15:0]        wr_data;
   logic               unused_addr_lsb;

   assign unused_addr_lsb = ioctl_addr[0];
   assign dl_rise  = ioctl_download & ~dl_prev_q;
   assign dl_fall  = ~ioctl_download & dl_prev_q;
   assign word_ok  = (ioctl_addr[24:ADDR_W+1] == '0);
   assign word_idx = ioctl_addr[ADDR_W:1];
   assign wr_top   = {1'b0, word_idx} + OneW;
   assign wr_data  = BYTE_SWAP ? {ioctl_dout[7:0], ioctl_dout[15:8]} : ioctl_dout;

   assign cpu_reset  = (state_q != StRun);
   assign ioctl_wait = (state_q == StClear);

   // Next-state and next-value logic for the sequencer and all registered outputs.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hw_d         = hw_q;
      clr_ptr_d    = clr_ptr_q;
      rom_we_d     = 1'b0;
      rom_addr_d   = rom_addr;
      rom_din_d    = rom_din;
      load_done_d  = load_done;
      overflow_d   = overflow;
      load_words_d = load_words;
      checksum_d   = checksum;

      unique case (state_q)
         StHold, StRun: begin
            if (dl_rise) begin
               state_d      = StLoad;
               load_done_d  = 1'b0;
               overflow_d   = 1'b0;
               load_words_d = '0;
               checksum_d   = '0;
               hw_d         = '0;
            end else if (state_q == StHold) begin
               if (cnt_q == '0) state_d = StRun;
               else             cnt_d   = cnt_q - CntW'(1);
            end
         end
         StLoad: begin
            if (ioctl_wr) begin
               if (word_ok) begin
                  rom_we_d   = 1'b1;
                  rom_addr_d = word_idx;
                  rom_din_d  = wr_data;
                  if (load_words != Depth) load_words_d = load_words + OneW;
                  checksum_d = checksum + wr_data;
                  if (wr_top > hw_q) hw_d = wr_top;
               end else begin
                  overflow_d = 1'b1;
               end
            end
            // hw_d already includes a strobe coincident with the falling edge
            if (dl_fall) begin
               if (CLEAR_TAIL && (hw_d < Depth)) begin
                  state_d   = StClear;
                  clr_ptr_d = hw_d[ADDR_W-1:0];
               end else begin
                  load_done_d = ~overflow_d;
                  cnt_d       = HoldInit;
                  state_d     = StHold;
               end
            end
         end
         StClear: begin
            rom_we_d   = 1'b1;
            rom_addr_d = clr_ptr_q;
            rom_din_d  = '0;
            if (&clr_ptr_q) begin
               load_done_d = ~overflow;
               cnt_d       = HoldInit;
               state_d     = StHold;
            end else begin
               clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            end
         end
         default: state_d = StHold;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= StHold;
         cnt_q      <= HoldInit;
         dl_prev_q  <= 1'b0;
         hw_q       <= '0;
         clr_ptr_q  <= '0;
         rom_we     <= 1'b0;
         rom_addr   <= '0;
         rom_din    <= '0;
         load_done  <= 1'b0;
         overflow   <= 1'b0;
         load_words <= '0;
         checksum   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dl_prev_q  <= ioctl_download;
         hw_q       <= hw_d;
         clr_ptr_q  <= clr_ptr_d;
         rom_we     <= rom_we_d;
         rom_addr   <= rom_addr_d;
         rom_din    <= rom_din_d;
         load_done  <= load_done_d;
         overflow   <= overflow_d;
         load_words <= load_words_d;
         checksum   <= checksum_d;
      end
   end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Bench for hack_rom_loader: two instances (tail-clearing, and byte-swapping without tail
// clear) share one download stream; a reference model predicts the ROM image and status.
module tb_hack_rom_loader;

   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned HOLD  = 16;

   logic        clk_sys = 1'b0;
   logic        reset, ioctl_download, ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [15:0] ioctl_dout;

   logic a_wait, a_we, a_cpu_reset, a_done, a_ovf;
   logic [AW-1:0] a_addr;
   logic [15:0] a_din, a_chk;
   logic [AW:0] a_words;
   logic b_wait, b_we, b_cpu_reset, b_done, b_ovf;
   logic [AW-1:0] b_addr;
   logic [15:0] b_din, b_chk;
   logic [AW:0] b_words;

   always #5 clk_sys = ~clk_sys;

   hack_rom_loader #(.ADDR_W(AW), .BYTE_SWAP(1'b0), .CLEAR_TAIL(1'b1), .HOLD_CYCLES(HOLD)) u_clr (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(a_wait), .rom_we(a_we),
      .rom_addr(a_addr), .rom_din(a_din), .cpu_reset(a_cpu_reset), .load_done(a_done),
      .overflow(a_ovf), .load_words(a_words), .checksum(a_chk)
   );

   hack_rom_loader #(.ADDR_W(AW), .BYTE_SWAP(1'b1), .CLEAR_TAIL(1'b0), .HOLD_CYCLES(HOLD)) u_swp (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(b_wait), .rom_we(b_we),
      .rom_addr(b_addr), .rom_din(b_din), .cpu_reset(b_cpu_reset), .load_done(b_done),
      .overflow(b_ovf), .load_words(b_words), .checksum(b_chk)
   );

   // ROM mirrors built from what each instance actually writes
   logic [15:0] mir_a[DEPTH], mir_b[DEPTH];
   int we_a = 0, we_b = 0;
   always @(negedge clk_sys) begin
      if (a_we) begin mir_a[a_addr] <= a_din; we_a <= we_a + 1; end
      if (b_we) begin mir_b[b_addr] <= b_din; we_b <= we_b + 1; end
   end

   // Reference model: expected ROM image, with a mask of words whose content is known
   logic [15:0] img_a[DEPTH], img_b[DEPTH];
   bit          val_a[DEPTH], val_b[DEPTH];

   typedef struct { logic [24:0] addr; logic [15:0] data; } wr_t;
   wr_t wq[$];

   int n_cmp = 0, n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   function automatic logic [15:0] swap16(input logic [15:0] d);
      return {d[7:0], d[15:8]};
   endfunction

   task automatic add_wr(input logic [24:0] a, input logic [15:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      wq.push_back(e);
   endtask

   task automatic build_random();
      int n;
      logic [24:0] a;
      wq.delete();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
         a = 25'($urandom_range(0, 35));
         if ($urandom_range(0, 9) == 0) a[22] = 1'b1;
         add_wr(a, 16'($urandom));
      end
   endtask

   // Counts cycles with cpu_reset high (current sample included) until both CPUs run.
   task automatic count_hold(output int ca, output int cb, output int wt);
      ca = 0; cb = 0; wt = 0;
      for (int t = 0; t < 300 && (a_cpu_reset || b_cpu_reset); t++) begin
         if (a_cpu_reset) ca++;
         if (b_cpu_reset) cb++;
         if (a_wait) wt++;
         step();
      end
   endtask

   // Runs one download of the queued writes and checks both instances against the model.
   task automatic run_download(input bit coincide, input bit gaps, input string tag);
      int acc = 0, hw = 0, n_clr, ca, cb, wt, wa0, wb0, exp_words;
      bit ovf = 1'b0;
      logic [15:0] chk_a = '0, chk_b = '0;
      foreach (wq[i]) begin
         int w;
         w = int'(wq[i].addr[24:1]);
         if (w < DEPTH) begin
            acc++;
            chk_a += wq[i].data;
            chk_b += swap16(wq[i].data);
            img_a[w] = wq[i].data;         val_a[w] = 1'b1;
            img_b[w] = swap16(wq[i].data); val_b[w] = 1'b1;
            if (w + 1 > hw) hw = w + 1;
         end else begin
            ovf = 1'b1;
         end
      end
      n_clr = DEPTH - hw;
      for (int k = hw; k < DEPTH; k++) begin img_a[k] = '0; val_a[k] = 1'b1; end
      exp_words = (acc > DEPTH) ? DEPTH : acc;

      wa0 = we_a; wb0 = we_b;
      ioctl_download = 1'b1; ioctl_wr = 1'b0;
      step();
      foreach (wq[i]) begin
         if (gaps && $urandom_range(0, 2) == 0) begin ioctl_wr = 1'b0; step(); end
         ioctl_wr   = 1'b1;
         ioctl_addr = wq[i].addr;
         ioctl_dout = wq[i].data;
         if (coincide && i == wq.size() - 1) ioctl_download = 1'b0;
         step();
      end
      ioctl_wr = 1'b0;
      if (ioctl_download) begin ioctl_download = 1'b0; step(); end

      count_hold(ca, cb, wt);
      check_eq({tag, " a_hold"}, 32'(ca), 32'(n_clr + HOLD + 1));
      check_eq({tag, " b_hold"}, 32'(cb), 32'(HOLD + 1));
      check_eq({tag, " a_wait_cycles"}, 32'(wt), 32'(n_clr));
      check_eq({tag, " a_we_count"}, 32'(we_a - wa0), 32'(acc + n_clr));
      check_eq({tag, " b_we_count"}, 32'(we_b - wb0), 32'(acc));
      check_eq({tag, " a_words"}, 32'(a_words), 32'(exp_words));
      check_eq({tag, " b_words"}, 32'(b_words), 32'(exp_words));
      check_eq({tag, " a_chk"}, 32'(a_chk), 32'(chk_a));
      check_eq({tag, " b_chk"}, 32'(b_chk), 32'(chk_b));
      check_eq({tag, " a_ovf"}, 32'(a_ovf), 32'(ovf));
      check_eq({tag, " b_ovf"}, 32'(b_ovf), 32'(ovf));
      check_eq({tag, " a_done"}, 32'(a_done), 32'(!ovf));
      check_eq({tag, " b_done"}, 32'(b_done), 32'(!ovf));
      for (int k = 0; k < DEPTH; k++) begin
         if (val_a[k]) check_eq($sformatf("%s rom_a[%0d]", tag, k), 32'(mir_a[k]), 32'(img_a[k]));
         if (val_b[k]) check_eq($sformatf("%s rom_b[%0d]", tag, k), 32'(mir_b[k]), 32'(img_b[k]));
      end
   endtask

   initial begin
      int ca, cb, wt, wa0;
      reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;

      // Power-up
      step(); step();
      check_eq("rst cpu_reset", 32'(a_cpu_reset), 32'd1);
      check_eq("rst rom_we", 32'(a_we), 32'd0);
      check_eq("rst rom_addr", 32'(a_addr), 32'd0);
      check_eq("rst rom_din", 32'(a_din), 32'd0);
      check_eq("rst ioctl_wait", 32'(a_wait), 32'd0);
      check_eq("rst load_done", 32'(a_done), 32'd0);
      check_eq("rst overflow", 32'(a_ovf), 32'd0);
      check_eq("rst load_words", 32'(a_words), 32'd0);
      check_eq("rst checksum", 32'(a_chk), 32'd0);
      reset = 1'b0;
      count_hold(ca, cb, wt);
      check_eq("pwr a_hold", 32'(ca), 32'(HOLD + 1));
      check_eq("pwr b_hold", 32'(cb), 32'(HOLD + 1));
      check_eq("pwr no_we", 32'(we_a + we_b), 32'd0);

      // Small Hack program
      wq.delete();
      add_wr(25'd0, 16'h0002); add_wr(25'd2, 16'hEC10);
      add_wr(25'd4, 16'h0000); add_wr(25'd6, 16'hE308);
      run_download(1'b0, 1'b0, "prog4");

      // Single word, byte-swap visible on instance b
      wq.delete();
      add_wr(25'd0, 16'h1234);
      run_download(1'b1, 1'b0, "swap");

      // Out-of-range write only
      wq.delete();
      add_wr(25'h20, 16'hBEEF);
      run_download(1'b0, 1'b0, "ovf");

      // Top word written on the falling edge: no tail clear
      wq.delete();
      add_wr(25'd2, 16'h1111); add_wr(25'd30, 16'hABCD);
      run_download(1'b1, 1'b0, "top15");

      // Strobes outside a download are ignored
      wa0 = we_a;
      ioctl_wr = 1'b1; ioctl_addr = 25'd4; ioctl_dout = 16'h7777;
      step();
      ioctl_wr = 1'b0;
      step(); step();
      check_eq("idle_wr no_we", 32'(we_a - wa0), 32'd0);

      // Reset in the middle of a tail clear
      ioctl_download = 1'b1; step();
      ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 16'h5A3C; step();
      ioctl_wr = 1'b0; ioctl_download = 1'b0; step();
      step(); step();
      check_eq("midclr wait_pre", 32'(a_wait), 32'd1);
      reset = 1'b1; step();
      check_eq("midclr rom_we", 32'(a_we), 32'd0);
      check_eq("midclr wait", 32'(a_wait), 32'd0);
      check_eq("midclr a_done", 32'(a_done), 32'd0);
      check_eq("midclr b_done", 32'(b_done), 32'd0);
      check_eq("midclr cpu_reset", 32'(a_cpu_reset), 32'd1);
      reset = 1'b0;
      for (int k = 0; k < DEPTH; k++) val_a[k] = 1'b0;
      img_b[0] = swap16(16'h5A3C); val_b[0] = 1'b1;
      count_hold(ca, cb, wt);
      check_eq("midclr a_hold", 32'(ca), 32'(HOLD + 1));
      check_eq("midclr b_hold", 32'(cb), 32'(HOLD + 1));

      // Randomized downloads
      for (int r = 0; r < 14; r++) begin
         build_random();
         run_download(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $sformatf("rnd%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
